// File: rtl/async_fifo_pkg.sv
// Gray/binary conversion helpers shared by the read-side empty and write-side full logic.
// Callers zero-extend narrower pointers to 32 bits and truncate the result back.
package async_fifo_pkg;

    localparam int GRAY_W = 32;

    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // XOR prefix from the MSB down; zero upper bits leave narrower pointers intact.
    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] gray);
        logic [GRAY_W-1:0] bin;
        bin[GRAY_W-1] = gray[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/rptr_empty_ctrl.sv
// Read-domain pointer, empty/almost-empty and fill-level logic for the async FIFO.
// Flags are pessimistic: reads count at once, while writes arrive through the synchroniser.
module rptr_empty_ctrl
    import async_fifo_pkg::*;
#(
    parameter int          ADDRSIZE     = 4,
    parameter int unsigned AEMPTY_LEVEL = 1
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                arempty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                rerr
);

    localparam int PW = ADDRSIZE + 1;

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbinnext;
    logic [PW-1:0] rgraynext;
    logic [PW-1:0] wbin;
    logic [PW-1:0] level_next;
    logic          rd_ok;

    // Next-pointer compare lets the final read set rempty on the edge that consumes it.
    always_comb begin
        rd_ok      = rinc & ~rempty;
        rbinnext   = rbin + PW'(rd_ok);
        rgraynext  = PW'(bin2gray(GRAY_W'(rbinnext)));
        wbin       = PW'(gray2bin(GRAY_W'(rq2_wptr)));
        level_next = wbin - rbinnext;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin    <= '0;
            rptr    <= '0;
            rempty  <= 1'b1;
            arempty <= 1'b1;
            rlevel  <= '0;
            rerr    <= 1'b0;
        end else begin
            rbin    <= rbinnext;
            rptr    <= rgraynext;
            rempty  <= (rgraynext == rq2_wptr);
            arempty <= (GRAY_W'(level_next) <= AEMPTY_LEVEL);
            rlevel  <= level_next;
            rerr    <= rinc & rempty;
        end
    end

    assign raddr = rbin[ADDRSIZE-1:0];

endmodule
